sisc_ifetch: RTL

Instruction-fetch stage of the SISC CPU, directly upstream of the control FSM. It owns the program counter and the instruction register (IR), and runs a req/ack read handshake to instruction memory. It supplies opcode/mm/immediate fields to the control FSM and datapath. It applies sequential or branch PC updates when the control FSM commands them.

---
 rtl/sisc_ifetch_if.sv | 31 +++
 rtl/sisc_ifetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read port of the SISC fetch stage.
//
// Handshake: the fetch stage raises req with a stable addr and holds both
// until the memory answers with ack=1 for one cycle; rdata is valid only in
// that cycle. The fetch stage drops req on the edge that samples ack, and an
// ack seen while req is low carries no meaning and must be ignored.
interface sisc_ifetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic [INSTR_W-1:0] rdata;
  logic               ack;

  // Fetch-stage side: issues the read and consumes the word.
  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  // Memory side: answers the read.
  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );
endinterface

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch stage: owns the program counter and the instruction
// register, reads instruction memory over a req/ack port, and applies
// sequential or conditional-branch PC updates commanded by the control FSM.
module sisc_ifetch #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_f,
  sisc_ifetch_if.master      mem,
  input  logic               fetch_req,
  input  logic               upd_pc,
  input  logic [3:0]         stat,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_done,
  output logic               busy,
  output logic               halted,
  output logic               err,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_BRR = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_BNR = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t          state;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] imm_zext;
  logic            flag_hit;
  logic            br_taken;
  logic [PC_W-1:0] br_target;

  // Instruction fields are plain slices of the IR.
  assign opcode = ir[31:28];
  assign mm     = ir[27:24];
  assign imm    = ir[15:0];

  // Immediate widened to PC width: sign-extended for relative branches,
  // zero-extended for absolute ones.
  if (PC_W > 16) begin : g_wide_pc
    assign imm_sext = {{(PC_W-16){imm[15]}}, imm};
    assign imm_zext = {{(PC_W-16){1'b0}}, imm};
  end else begin : g_narrow_pc
    assign imm_sext = imm[PC_W-1:0];
    assign imm_zext = imm[PC_W-1:0];
  end

  assign flag_hit = |(stat & mm);

  // Branch decision for the instruction held in IR; pc is already the
  // incremented value, so relative targets are taken from the next address.
  always_comb begin
    br_taken  = 1'b0;
    br_target = pc;
    case (opcode)
      OP_BRA: begin
        br_taken  = flag_hit;
        br_target = imm_zext;
      end
      OP_BRR: begin
        br_taken  = flag_hit;
        br_target = pc + imm_sext;
      end
      OP_BNE: begin
        br_taken  = !flag_hit;
        br_target = imm_zext;
      end
      OP_BNR: begin
        br_taken  = !flag_hit;
        br_target = pc + imm_sext;
      end
      default: begin
        br_taken  = 1'b0;
        br_target = pc;
      end
    endcase
  end

  // The memory address is the PC itself; it only changes after ack, so it is
  // stable for the whole request.
  assign mem.addr  = pc;
  assign busy      = (state == WAIT_ACK);
  assign state_dbg = state;

  // Fetch FSM together with PC, IR and the sticky status flags.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      mem.req    <= 1'b0;
      fetch_done <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_pc) begin
            // A fetch requested together with a PC commit is a control
            // error; the commit wins and the fetch is dropped.
            if (fetch_req) begin
              err <= 1'b1;
            end
            if (br_taken) begin
              pc <= br_target;
            end
          end else if (fetch_req && !halted) begin
            mem.req <= 1'b1;
            state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (fetch_req || upd_pc) begin
            err <= 1'b1;
          end
          if (mem.ack) begin
            ir         <= mem.rdata;
            pc         <= pc + PC_W'(1);
            mem.req    <= 1'b0;
            fetch_done <= 1'b1;
            state      <= DONE;
            if (mem.rdata[INSTR_W-1 -: 4] == OP_HLT) begin
              halted <= 1'b1;
            end
          end
        end
        DONE: begin
          if (fetch_req || upd_pc) begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          mem.req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
